// File: rtl/master_vldrdy.sv
// master_vldrdy: valid/ready stream source emitting counter or LFSR bursts.
// Ports: clk, rst (sync, active-high); cfg_en/cfg_mode/cfg_len/cfg_gap
//   configure a burst; start launches it; busy/done/sent_cnt report
//   progress; src_val/src_rdy/src_data form the outgoing stream.
module master_vldrdy #(
    parameter int                DWIDTH = 8,
    parameter logic [DWIDTH-1:0] POLY   = DWIDTH'(8'hB8),
    parameter logic [DWIDTH-1:0] SEED   = DWIDTH'(1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_mode,
    input  logic [15:0]       cfg_len,
    input  logic [3:0]        cfg_gap,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       sent_cnt,
    output logic              src_val,
    input  logic              src_rdy,
    output logic [DWIDTH-1:0] src_data
);

    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [DWIDTH-1:0] SEED_EFF =
        (SEED == '0) ? DWIDTH'(1) : SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              val_q, val_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [15:0]       len_q, len_d;
    logic [3:0]        gap_q, gap_d;
    logic [3:0]        gcnt_q, gcnt_d;

    logic              xfer;
    logic [15:0]       cnt_inc;
    logic [DWIDTH-1:0] data_nxt;

    // Next pattern word from the current one, in the latched mode.
    function automatic logic [DWIDTH-1:0] pat_next(
        input logic              m,
        input logic [DWIDTH-1:0] x
    );
        if (m) begin
            return (x >> 1) ^ (x[0] ? POLY : '0);
        end
        return x + DWIDTH'(1);
    endfunction

    assign xfer     = val_q & src_rdy;
    assign cnt_inc  = cnt_q + 16'd1;
    assign data_nxt = pat_next(mode_q, data_q);

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;

        if (!cfg_en) begin
            // Abort: drop any pending word, but a word taken this
            // very cycle is still counted.
            state_d = S_IDLE;
            val_d   = 1'b0;
            busy_d  = 1'b0;
            if (xfer) begin
                cnt_d  = cnt_inc;
                data_d = data_nxt;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_SEND;
                        val_d   = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        mode_d  = cfg_mode;
                        len_d   = cfg_len;
                        gap_d   = cfg_gap;
                        data_d  = cfg_mode ? SEED_EFF : '0;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        cnt_d  = cnt_inc;
                        data_d = data_nxt;
                        if (len_q != 16'd0 && cnt_inc == len_q) begin
                            state_d = S_DONE;
                            val_d   = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q != 4'd0) begin
                            state_d = S_GAP;
                            val_d   = 1'b0;
                            gcnt_d  = gap_q;
                        end
                    end
                end
                S_GAP: begin
                    gcnt_d = gcnt_q - 4'd1;
                    if (gcnt_q == 4'd1) begin
                        state_d = S_SEND;
                        val_d   = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    val_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            val_q   <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            len_q   <= '0;
            gap_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign src_val  = val_q;
    assign src_data = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sent_cnt = cnt_q;

endmodule

// File: tb/tb_master_vldrdy.sv
// tb_master_vldrdy: directed stimulus against a burst-level model
// of master_vldrdy (DWIDTH=8, POLY=B8, SEED=1).
module tb_master_vldrdy;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_en;
    logic        cfg_mode;
    logic [15:0] cfg_len;
    logic [3:0]  cfg_gap;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] sent_cnt;
    logic        src_val;
    logic        src_rdy;
    logic [7:0]  src_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    master_vldrdy #(.DWIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_en   (cfg_en),
        .cfg_mode (cfg_mode),
        .cfg_len  (cfg_len),
        .cfg_gap  (cfg_gap),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt),
        .src_val  (src_val),
        .src_rdy  (src_rdy),
        .src_data (src_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // k-th word of a burst, straight from the pattern definition.
    function automatic logic [7:0] word(input bit md, input int n);
        logic [7:0] x;
        if (!md) return n[7:0];
        x = 8'h01;
        for (int i = 0; i < n; i++)
            x = (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
        return x;
    endfunction

    // Burst-level model: expected outputs for the cycle after each edge.
    logic        m_val, m_busy, m_done;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    logic [15:0] mL;
    logic [3:0]  mG;
    bit          mM;
    int          k;
    int          idle_left;

    always @(posedge clk) begin
        bit xfer, was_done;
        cyc++;
        if (rst) begin
            m_val = 0; m_busy = 0; m_done = 0;
            m_data = 0; m_cnt = 0; k = 0; idle_left = 0;
        end else begin
            xfer     = m_val && src_rdy;
            was_done = m_done;
            m_done   = 0;
            if (xfer) begin
                m_cnt++;
                k++;
            end
            if (!cfg_en) begin
                m_val  = 0;
                m_busy = 0;
            end else if (!m_busy && !was_done) begin
                if (start) begin
                    mL = cfg_len; mG = cfg_gap; mM = cfg_mode;
                    m_cnt = 0; k = 0;
                    m_val = 1; m_busy = 1;
                    m_data = word(mM, 0);
                end
            end else if (m_busy) begin
                if (xfer) begin
                    if (mL != 0 && m_cnt == mL) begin
                        m_val = 0; m_busy = 0; m_done = 1;
                    end else if (mG != 0) begin
                        m_val = 0;
                        idle_left = int'(mG);
                    end else begin
                        m_data = word(mM, k);
                    end
                end else if (!m_val) begin
                    idle_left--;
                    if (idle_left == 0) begin
                        m_val  = 1;
                        m_data = word(mM, k);
                    end
                end
            end
        end
    end

    // Accepted words, collected for literal checks.
    logic [7:0] xq[$];

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("val", 32'(src_val), 32'(m_val));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("sent_cnt", 32'(sent_cnt), 32'(m_cnt));
            if (m_val) chk("data", 32'(src_data), 32'(m_data));
            if (src_val && src_rdy) xq.push_back(src_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_burst(input bit md, input logic [15:0] len,
                               input logic [3:0] gap);
        cfg_mode = md;
        cfg_len  = len;
        cfg_gap  = gap;
        xq.delete();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lf[4];
        bit         gp[7];
        logic [15:0] c0;

        rst = 1; start = 1; cfg_en = 1; cfg_mode = 0;
        cfg_len = 4; cfg_gap = 0; src_rdy = 1;

        // Reset held with start high: everything stays at zero.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_val", 32'(src_val), 32'd0);
            chk("rst_data", 32'(src_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_cnt", 32'(sent_cnt), 32'd0);
        end
        rst = 0; start = 0;
        repeat (3) tick();
        chk("idle_val", 32'(src_val), 32'd0);

        // Counter burst, no back-pressure.
        start_burst(0, 4, 0);
        chk("lat_val", 32'(src_val), 32'd1);
        chk("lat_data", 32'(src_data), 32'd0);
        wait_done(20);
        chk("c4_cnt", 32'(sent_cnt), 32'd4);
        chk("c4_n", 32'(xq.size()), 32'd4);
        for (int i = 0; i < 4 && i < xq.size(); i++)
            chk("c4_word", 32'(xq[i]), i);
        tick();
        chk("c4_idle_busy", 32'(busy), 32'd0);

        // Back-pressure while word 2 is offered.
        start_burst(0, 4, 0);
        tick();
        tick();
        src_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_val", 32'(src_val), 32'd1);
            chk("bp_data", 32'(src_data), 32'd2);
            tick();
        end
        chk("bp_val4", 32'(src_val), 32'd1);
        chk("bp_data4", 32'(src_data), 32'd2);
        src_rdy = 1;
        wait_done(20);
        chk("bp_cnt", 32'(sent_cnt), 32'd4);
        tick();

        // Gap of two idle cycles.
        gp = '{1, 0, 0, 1, 0, 0, 1};
        start_burst(0, 4, 2);
        for (int i = 0; i < 7; i++) begin
            chk("gap_val", 32'(src_val), 32'(gp[i]));
            tick();
        end
        wait_done(20);
        tick();

        // LFSR burst.
        lf = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        start_burst(1, 4, 0);
        wait_done(20);
        chk("lf_n", 32'(xq.size()), 32'd4);
        for (int i = 0; i < 4 && i < xq.size(); i++)
            chk("lf_word", 32'(xq[i]), 32'(lf[i]));
        tick();

        // Counter wrap over 300 words.
        start_burst(0, 300, 0);
        wait_done(400);
        chk("w_cnt", 32'(sent_cnt), 32'd300);
        chk("w_n", 32'(xq.size()), 32'd300);
        if (xq.size() > 256) begin
            chk("w_255", 32'(xq[255]), 32'hFF);
            chk("w_256", 32'(xq[256]), 32'h00);
        end
        tick();

        // Disable mid-burst with the sink stalled.
        start_burst(0, 10, 0);
        repeat (5) tick();
        src_rdy = 0;
        cfg_en  = 0;
        tick();
        chk("dis_val", 32'(src_val), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_done", 32'(done), 32'd0);
        chk("dis_cnt", 32'(sent_cnt), 32'd5);
        tick();
        cfg_en  = 1;
        src_rdy = 1;
        tick();
        start_burst(0, 10, 0);
        chk("re_cnt", 32'(sent_cnt), 32'd0);
        chk("re_data", 32'(src_data), 32'd0);
        tick();
        c0 = sent_cnt;
        start = 1;
        tick();
        start = 0;
        chk("ign_start", 32'(sent_cnt), 32'(c0 + 16'd1));
        wait_done(30);
        chk("re_done_cnt", 32'(sent_cnt), 32'd10);
        chk("re_n", 32'(xq.size()), 32'd10);
        for (int i = 0; i < 10 && i < xq.size(); i++)
            chk("re_word", 32'(xq[i]), i);
        tick();

        // Reset in the middle of an unlimited burst.
        start_burst(1, 0, 0);
        repeat (3) tick();
        rst = 1;
        tick();
        chk("mr_val", 32'(src_val), 32'd0);
        chk("mr_data", 32'(src_data), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_cnt", 32'(sent_cnt), 32'd0);
        rst = 0;
        repeat (2) tick();
        chk("mr_idle", 32'(src_val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
